// File: rtl/dbg_hex_scanner.sv
// Walks NUM_WORDS debug words, snapshots each one and streams its eight hex
// characters (MS nibble first) into the character buffer over a valid/ready port.
module dbg_hex_scanner #(
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned STRIDE    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              auto,
  output logic [IDX_W-1:0]  word_sel,
  input  logic [31:0]       word_in,
  output logic [3:0]        nib_out,
  input  logic [7:0]        asc_in,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CHAR_W = 3;
  localparam logic [CHAR_W-1:0] LAST_CHAR = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEL  = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CHAR_W-1:0]   r_char;
  logic [CHAR_W-1:0]   w_char_nxt;
  logic [31:0]         r_shadow;
  logic [31:0]         w_shadow_nxt;
  logic [3:0]          r_nib;
  logic [3:0]          w_nib_nxt;
  logic                r_wr_valid;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                r_busy;
  logic                r_done;
  logic [4:0]          w_nib_lsb;

  // Next-state, counters and snapshot
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_char_nxt   = r_char;
    w_shadow_nxt = r_shadow;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_SEL;
        end
      end
      S_SEL: begin
        w_shadow_nxt = word_in;
        w_char_nxt   = '0;
        w_state_nxt  = S_EMIT;
      end
      S_EMIT: begin
        if (wr_ready) begin
          if (r_char != LAST_CHAR) begin
            w_char_nxt = r_char + CHAR_W'(1);
          end else if (r_idx != LAST_IDX) begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_SEL;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (auto) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_SEL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Character c of the snapshot sits at bits [31-4c -: 4]; 7-c is ~c at 3 bits.
  always_comb begin
    w_nib_lsb  = {~w_char_nxt, 2'b00};
    w_nib_nxt  = (w_state_nxt == S_EMIT) ? w_shadow_nxt[w_nib_lsb +: 4] : 4'h0;
    w_addr_nxt = ADDR_W'(BASE_ADDR) + ADDR_W'(w_idx_nxt) * ADDR_W'(STRIDE)
               + ADDR_W'(w_char_nxt);
  end

  // State register with outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_char     <= '0;
      r_shadow   <= '0;
      r_nib      <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_char     <= w_char_nxt;
      r_shadow   <= w_shadow_nxt;
      r_nib      <= w_nib_nxt;
      r_wr_valid <= (w_state_nxt == S_EMIT);
      r_wr_addr  <= w_addr_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  // The converter is combinational from nib_out, so the data path passes straight through.
  assign wr_data  = r_wr_valid ? asc_in : 8'h00;
  assign word_sel = r_idx;
  assign nib_out  = r_nib;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
